// File: rtl/dac_jesd204_tx_framer.sv
// JESD204 transmit framer: buffers DAC sample beats in a small FIFO and maps
// channel-major 16-bit samples onto per-lane octets, with underflow accounting.
module dac_jesd204_tx_framer #(
    parameter int NUM_LANES       = 1,
    parameter int NUM_CHANNELS    = 1,
    parameter int TWOS_COMPLEMENT = 1
) (
    input  logic                      tx_clk,
    input  logic                      tx_rstn,
    input  logic                      tx_en,
    input  logic [NUM_CHANNELS-1:0]   dac_enable,
    input  logic                      dac_valid,
    input  logic [NUM_LANES*32-1:0]   dac_data,
    output logic                      dac_ready,
    input  logic                      tx_ready,
    output logic                      tx_valid,
    output logic [NUM_LANES*32-1:0]   tx_data,
    output logic                      dac_dunf,
    output logic [15:0]               dunf_count,
    input  logic                      dunf_clr
);

    localparam int SPC   = 2 * NUM_LANES / NUM_CHANNELS;
    localparam int DEPTH = 4;
    localparam int W     = NUM_LANES * 32;
    localparam int NS    = 2 * NUM_LANES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] mem [DEPTH];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [2:0]   occupancy;
    logic         push;
    logic         pop;
    logic         dunf_evt;
    logic [W-1:0] framed;
    logic [15:0]  sample;

    // Source handshake: a beat transfers on any rising edge where dac_valid
    // and dac_ready are both high; dac_ready never depends on dac_valid.
    assign dac_ready = (state != IDLE) && (occupancy < 3'(DEPTH));
    assign push      = dac_valid && dac_ready;
    assign pop       = (state == RUN) && tx_en && tx_ready && (occupancy != 3'd0);
    assign dunf_evt  = (state == RUN) && tx_en && tx_ready && (occupancy == 3'd0);

    // Even samples occupy the low half of a lane, odd samples the high half,
    // each stored MSB octet first.
    always_comb begin
        framed = '0;
        sample = '0;
        for (int j = 0; j < NS; j++) begin
            sample = mem[rd_ptr][j*16 +: 16];
            if (!dac_enable[j/SPC]) begin
                sample = '0;
            end
            if (TWOS_COMPLEMENT == 0) begin
                sample[15] = ~sample[15];
            end
            if (j % 2 == 0) begin
                framed[(j/2)*32      +: 8] = sample[15:8];
                framed[(j/2)*32 + 8  +: 8] = sample[7:0];
            end else begin
                framed[(j/2)*32 + 16 +: 8] = sample[15:8];
                framed[(j/2)*32 + 24 +: 8] = sample[7:0];
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (push) begin
            mem[wr_ptr] <= dac_data;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            dac_dunf   <= 1'b0;
            dunf_count <= '0;
        end else begin
            dac_dunf <= 1'b0;
            if (!tx_en) begin
                // Stopping always flushes, so a restart must re-prime the FIFO.
                state     <= IDLE;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
                tx_data   <= '0;
                tx_valid  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end
                occupancy <= occupancy + 3'(push) - 3'(pop);
                case (state)
                    IDLE: begin
                        state    <= PRIME;
                        tx_data  <= '0;
                        tx_valid <= 1'b0;
                    end
                    PRIME: begin
                        tx_data <= '0;
                        if (occupancy >= 3'd2) begin
                            state    <= RUN;
                            tx_valid <= 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                        end
                    end
                    RUN: begin
                        tx_valid <= 1'b1;
                        if (pop) begin
                            tx_data <= framed;
                        end else if (dunf_evt) begin
                            tx_data  <= '0;
                            dac_dunf <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tx_data  <= '0;
                        tx_valid <= 1'b0;
                    end
                endcase
            end

            if (dunf_clr) begin
                dunf_count <= '0;
            end else if (dunf_evt && (dunf_count != 16'hFFFF)) begin
                dunf_count <= dunf_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_jesd204_tx_framer.sv
// Bench for dac_jesd204_tx_framer: two instances (two's complement and offset
// binary) driven in lockstep against a queue-based reference model.
module tb_dac_jesd204_tx_framer;

    localparam int NL = 2;
    localparam int NC = 2;
    localparam int W  = NL * 32;

    logic          tx_clk = 1'b0;
    logic          tx_rstn;
    logic          tx_en;
    logic [NC-1:0] dac_enable;
    logic          dac_valid;
    logic [W-1:0]  dac_data;
    logic          tx_ready;
    logic          dunf_clr;

    logic          dac_ready_tc, tx_valid_tc, dac_dunf_tc;
    logic [W-1:0]  tx_data_tc;
    logic [15:0]   dunf_count_tc;
    logic          dac_ready_ob, tx_valid_ob, dac_dunf_ob;
    logic [W-1:0]  tx_data_ob;
    logic [15:0]   dunf_count_ob;

    dac_jesd204_tx_framer #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .TWOS_COMPLEMENT(1)) u_tc (
        .tx_clk(tx_clk), .tx_rstn(tx_rstn), .tx_en(tx_en), .dac_enable(dac_enable),
        .dac_valid(dac_valid), .dac_data(dac_data), .dac_ready(dac_ready_tc),
        .tx_ready(tx_ready), .tx_valid(tx_valid_tc), .tx_data(tx_data_tc),
        .dac_dunf(dac_dunf_tc), .dunf_count(dunf_count_tc), .dunf_clr(dunf_clr)
    );

    dac_jesd204_tx_framer #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .TWOS_COMPLEMENT(0)) u_ob (
        .tx_clk(tx_clk), .tx_rstn(tx_rstn), .tx_en(tx_en), .dac_enable(dac_enable),
        .dac_valid(dac_valid), .dac_data(dac_data), .dac_ready(dac_ready_ob),
        .tx_ready(tx_ready), .tx_valid(tx_valid_ob), .tx_data(tx_data_ob),
        .dac_dunf(dac_dunf_ob), .dunf_count(dunf_count_ob), .dunf_clr(dunf_clr)
    );

    // Clock / reset
    always #5 tx_clk = ~tx_clk;

    // Scoreboard and reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_ob_q[$];
    logic [W-1:0] nxt_tc, nxt_ob;
    int           m_state;   // 0 idle, 1 prime, 2 run
    logic [W-1:0] m_data, m_data_ob;
    logic         m_valid, m_dunf;
    logic [15:0]  m_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0]  data;
        logic [NC-1:0] en;
        logic [W-1:0]  exp_tc;
        logic [W-1:0]  exp_ob;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] frame(input logic [W-1:0] d, input logic [NC-1:0] en, input bit ob);
        logic [W-1:0] out;
        logic [15:0]  v;
        int           base;
        out = '0;
        for (int s = 0; s < 2 * NL; s++) begin
            v = en[s/2] ? d[s*16 +: 16] : 16'h0000;
            if (ob) v = v ^ 16'h8000;
            base = (s / 2) * 32 + (s % 2) * 16;
            out[base +: 8]     = v[15:8];
            out[base + 8 +: 8] = v[7:0];
        end
        return out;
    endfunction

    function automatic bit m_ready();
        return (m_state != 0) && (exp_q.size() < 4);
    endfunction

    task automatic model_reset();
        m_state   = 0;
        exp_q.delete();
        exp_ob_q.delete();
        m_data    = '0;
        m_data_ob = '0;
        m_valid   = 1'b0;
        m_dunf    = 1'b0;
        m_count   = '0;
    endtask

    task automatic model_update();
        bit push, uf;
        if (!tx_rstn) begin
            model_reset();
            return;
        end
        push   = dac_valid && m_ready();
        uf     = 1'b0;
        m_dunf = 1'b0;
        if (!tx_en) begin
            m_state   = 0;
            exp_q.delete();
            exp_ob_q.delete();
            m_data    = '0;
            m_data_ob = '0;
            m_valid   = 1'b0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (exp_q.size() >= 2) m_state = 2;
                default: begin
                    if (tx_ready) begin
                        if (exp_q.size() > 0) begin
                            m_data    = exp_q.pop_front();
                            m_data_ob = exp_ob_q.pop_front();
                        end else begin
                            m_data    = '0;
                            m_data_ob = '0;
                            m_dunf    = 1'b1;
                            uf        = 1'b1;
                        end
                    end
                end
            endcase
            m_valid = (m_state == 2);
            if (push) begin
                exp_q.push_back(nxt_tc);
                exp_ob_q.push_back(nxt_ob);
            end
        end
        if (dunf_clr) m_count = '0;
        else if (uf && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    endtask

    task automatic compare_all();
        check("tc.tx_valid",   W'(tx_valid_tc),   W'(m_valid));
        check("tc.tx_data",    tx_data_tc,        m_data);
        check("tc.dac_ready",  W'(dac_ready_tc),  W'(m_ready()));
        check("tc.dac_dunf",   W'(dac_dunf_tc),   W'(m_dunf));
        check("tc.dunf_count", W'(dunf_count_tc), W'(m_count));
        check("ob.tx_valid",   W'(tx_valid_ob),   W'(m_valid));
        check("ob.tx_data",    tx_data_ob,        m_data_ob);
        check("ob.dac_ready",  W'(dac_ready_ob),  W'(m_ready()));
        check("ob.dac_dunf",   W'(dac_dunf_ob),   W'(m_dunf));
        check("ob.dunf_count", W'(dunf_count_ob), W'(m_count));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge tx_clk);
        model_update();
        @(negedge tx_clk);
        compare_all();
    endtask

    // Driver tasks
    task automatic set_beat(input logic [W-1:0] d, input logic [W-1:0] e_tc, input logic [W-1:0] e_ob);
        dac_data = d;
        nxt_tc   = e_tc;
        nxt_ob   = e_ob;
    endtask

    task automatic set_rand_beat();
        logic [W-1:0] d;
        d = {$urandom(), $urandom()};
        set_beat(d, frame(d, dac_enable, 1'b0), frame(d, dac_enable, 1'b1));
    endtask

    task automatic restart_with_two_beats();
        tx_en = 1'b0; dac_valid = 1'b0; tx_ready = 1'b0;
        step();
        tx_en = 1'b1;
        step();
        dac_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_rand_beat();
            step();
        end
        dac_valid = 1'b0;
        step();
    endtask

    initial begin
        int pulses;

        vecs[0] = '{64'hDEF0_9ABC_5678_1234, 2'b11, 64'hF0DEBC9A_78563412, 64'hF05EBC1A_78D63492};
        vecs[1] = '{64'hDEF0_9ABC_5678_1234, 2'b01, 64'h00000000_78563412, 64'h00800080_78D63492};
        vecs[2] = '{64'hDEF0_9ABC_5678_1234, 2'b10, 64'hF0DEBC9A_00000000, 64'hF05EBC1A_00800080};
        vecs[3] = '{64'hFFFF_0001_7FFF_8000, 2'b11, 64'hFFFF0100_FF7F0080, 64'hFF7F0180_FFFF0000};
        vecs[4] = '{64'hDEF0_9ABC_5678_1234, 2'b00, 64'h00000000_00000000, 64'h00800080_00800080};

        tx_rstn = 1'b0; tx_en = 1'b1; dac_enable = 2'b11; dac_valid = 1'b1;
        dac_data = '0; tx_ready = 1'b1; dunf_clr = 1'b0; nxt_tc = '0; nxt_ob = '0;
        model_reset();

        // Reset holds everything quiet even with tx_en and dac_valid high.
        for (int i = 0; i < 3; i++) step();
        check("rst.tx_valid",   W'(tx_valid_tc),   '0);
        check("rst.tx_data",    tx_data_tc,        '0);
        check("rst.dac_ready",  W'(dac_ready_tc),  '0);
        check("rst.dac_dunf",   W'(dac_dunf_tc),   '0);
        check("rst.dunf_count", W'(dunf_count_tc), '0);
        dac_valid = 1'b0;
        tx_rstn   = 1'b1;
        step();
        check("rel.dac_ready", W'(dac_ready_tc), W'(1));
        check("rel.tx_valid",  W'(tx_valid_tc),  '0);

        // Table-driven framing vectors, each on a fresh stream.
        for (int v = 0; v < 5; v++) begin
            tx_en = 1'b0; dac_valid = 1'b0;
            step();
            dac_enable = vecs[v].en;
            tx_en = 1'b1; tx_ready = 1'b1;
            step();
            dac_valid = 1'b1;
            set_beat(vecs[v].data, vecs[v].exp_tc, vecs[v].exp_ob);
            step();
            set_beat('0, '0, 64'h00800080_00800080);
            step();
            dac_valid = 1'b0;
            for (int i = 0; i < 2; i++) step();
            check("vec.tc_data", tx_data_tc, vecs[v].exp_tc);
            check("vec.ob_data", tx_data_ob, vecs[v].exp_ob);
            for (int i = 0; i < 2; i++) step();
        end

        // Two buffered beats drained for five cycles: three underflows.
        dac_enable = 2'b11;
        restart_with_two_beats();
        dunf_clr = 1'b1;
        step();
        dunf_clr = 1'b0;
        tx_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(dac_dunf_tc);
        end
        tx_ready = 1'b0;
        step();
        pulses += int'(dac_dunf_tc);
        check("dunf.pulses", W'(pulses), W'(3));
        check("dunf.count3", W'(dunf_count_tc), W'(3));
        dunf_clr = 1'b1;
        step();
        dunf_clr = 1'b0;
        check("dunf.cleared", W'(dunf_count_tc), '0);

        // Backpressure: fill to four, pop, push+pop together, hold, then flush.
        dac_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rand_beat();
            step();
        end
        check("bp.full_ready", W'(dac_ready_tc), '0);
        tx_ready = 1'b1;
        step();
        set_rand_beat();
        step();
        tx_ready = 1'b0; dac_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        tx_en = 1'b0;
        step();
        check("flush.tx_data",   tx_data_tc,       '0);
        check("flush.tx_valid",  W'(tx_valid_tc),  '0);
        check("flush.dac_ready", W'(dac_ready_tc), '0);
        tx_en = 1'b1;
        step();
        check("flush.reprime_ready", W'(dac_ready_tc), W'(1));

        // Mid-stream reset discards buffered beats; restart goes through PRIME.
        restart_with_two_beats();
        tx_ready = 1'b1;
        step();
        #1;
        tx_rstn = 1'b0;
        model_reset();
        #1;
        check("mrst.tx_data",   tx_data_tc,       '0);
        check("mrst.tx_valid",  W'(tx_valid_tc),  '0);
        check("mrst.dac_ready", W'(dac_ready_tc), '0);
        @(negedge tx_clk);
        step();
        tx_rstn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("mrst.primed_valid", W'(tx_valid_tc), '0);
        check("mrst.no_dunf",      W'(dac_dunf_tc), '0);

        // Random traffic with occasional stops and counter clears.
        dac_enable = NC'($urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            tx_en     = ($urandom_range(0, 39) != 0);
            dac_valid = $urandom_range(0, 1);
            tx_ready  = ($urandom_range(0, 3) != 0);
            dunf_clr  = ($urandom_range(0, 49) == 0);
            set_rand_beat();
            step();
        end
        dunf_clr = 1'b0;

        // Saturation: 0x10005 underflows pin the counter at 0xFFFF.
        restart_with_two_beats();
        dunf_clr = 1'b1;
        step();
        dunf_clr = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 2 + 32'h10005; i++) step();
        check("sat.count", W'(dunf_count_tc), W'(16'hFFFF));
        check("sat.pulse", W'(dac_dunf_tc),   W'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
